serial_nibble_adder: RTL

- Multi-cycle wide adder/subtractor built around one 4-bit add slice (Cin, A, B -> S, Cout, V semantics).
- Processes one nibble per clock, LSB nibble first, chaining carry through a register.
- Drives the 4-bit adder stage with operand nibbles and consumes its S/Cout/V outputs.
- Result is presented to downstream logic with a one-cycle done pulse.

---
 rtl/serial_nibble_adder.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: W-bit add/subtract computed one nibble per clock through a single 4-bit slice.
module nibble_add4 (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       cout,
    output logic       v
);
    logic [3:0] lo;
    assign lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b0, cin};
    assign {cout, s[3]} = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, lo[3]};
    assign s[2:0] = lo[2:0];
    assign v = lo[3] ^ cout;
endmodule

module serial_nibble_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW+1:0] sh;
    logic [3:0]    a_nib, b_nib, s;
    logic          c, v;
    assign sh = {idx_q, 2'b00};
    assign a_nib = 4'(a_q >> sh);
    assign b_nib = 4'(b_q >> sh);
    nibble_add4 u_slice (.cin(carry_q), .a(a_nib), .b(b_nib), .s(s), .cout(c), .v(v));
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        carry_d = carry_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        cout_d = cout_q;
        ovf_d = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ADD;
                idx_d = '0;
                carry_d = sub | cin;
                a_d = a;
                b_d = sub ? ~b : b;
                sum_d = '0;
            end
            ADD: begin
                sum_d = (sum_q & ~(W'(4'hF) << sh)) | (W'(s) << sh);
                carry_d = c;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    state_d = DONE;
                    cout_d = c;
                    ovf_d = v;
                end else idx_d = idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            carry_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            carry_q <= carry_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            cout_q <= cout_d;
            ovf_q <= ovf_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign sum = sum_q;
    assign cout = cout_q;
    assign ovf = ovf_q;
endmodule
